psum_add_arbiter: RTL
=====================

PSUM_ADD_ARBITER -- requirements
Module: psum_add_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one saturating adder (2..8).
REQ-002 SHALL use data width `PSUM_DATA_SIZE` (12): signed fixed point (12,5); IDW = clog2(NREQ).
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  in  NREQ  per-requester operand-pair valid.
REQ-006 SHALL have port req_a  in  NREQ*PSUM_DATA_SIZE  operand A; requester i occupies slice [i*W +: W].
REQ-007 SHALL have port req_b  in  NREQ*PSUM_DATA_SIZE  operand B, same packing.
REQ-008 SHALL have port req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-009 SHALL have port out_valid  out  1  result register holds a valid sum.
REQ-010 SHALL have port out_ready  in  1  consumer accepts result.
REQ-011 SHALL have port out_data  out  PSUM_DATA_SIZE  saturated sum.
REQ-012 SHALL have port out_id  out  IDW  index of the requester that produced out_data.
REQ-013 SHALL have port sat_cnt  out  8  count of saturated results.
REQ-014 SHALL have port sat_cnt_clr  in  1  synchronous clear of sat_cnt.

Function
REQ-015 SHALL select grant index g as the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ; grant is combinational from req_valid and rr_ptr only.
REQ-016 SHALL define can_accept = ~out_valid | out_ready.
REQ-017 SHALL drive req_ready[g] = can_accept for the granted requester and 0 for all others; all zero if no req_valid.
REQ-018 SHALL treat a transfer as req_valid[g] & req_ready[g]; exactly one transfer per cycle maximum.
REQ-019 SHALL compute sum = sign-extended req_a[g] + req_b[g] at W+1 bits.
REQ-020 SHALL saturate: sum > 2047 -> 12'h7FF; sum < -2048 -> 12'h800; otherwise sum[W-1:0].
REQ-021 On a transfer, SHALL load out_data, out_id <= g and out_valid <= 1 at the next edge (latency 1 cycle).
REQ-022 With no transfer and out_ready=1, SHALL clear out_valid; out_data and out_id hold.
REQ-023 With out_valid=1 and out_ready=0, SHALL hold out_valid, out_data and out_id stable and drive all req_ready 0.
REQ-024 Simultaneous drain and transfer (out_valid=1, out_ready=1) SHALL replace the result with no bubble, sustaining 1 result/cycle.
REQ-025 On a transfer, SHALL set rr_ptr <= (g+1) mod NREQ; with no transfer rr_ptr SHALL hold, even if requests are pending.
REQ-026 SHALL increment sat_cnt by 1 on each transfer whose result saturated, stopping at 255 (no wrap).
REQ-027 sat_cnt_clr SHALL take priority: sat_cnt <= 0 even if a saturating transfer occurs in the same cycle.
REQ-028 SHALL not let any requester starve: with all requesters valid and out_ready held 1, each is granted once every NREQ cycles.

Reset
REQ-029 While reset=1, SHALL force out_valid=0, out_data=0, out_id=0, rr_ptr=0 and sat_cnt=0 at the clock edge.
REQ-030 While reset=1, SHALL drive req_ready all 0; no transfer is counted.
REQ-031 Reset asserted with a pending result SHALL discard it; no out_valid appears after reset deasserts until a new transfer.

Verification
REQ-032 Single request: req_valid=4'b0100, a=12'h100, b=12'h050, out_ready=1 -> req_ready=4'b0100; next cycle out_valid=1, out_data=12'h150, out_id=2; rr_ptr=3.
REQ-033 Saturation: a=12'h7F0, b=12'h020 -> out_data=12'h7FF, sat_cnt=1; a=12'h800, b=12'hFFF -> out_data=12'h800, sat_cnt=2; a=12'h400, b=12'hC00 -> 12'h000, sat_cnt unchanged.
REQ-034 Round robin: req_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles, no bubbles.
REQ-035 Backpressure: result pending, out_ready=0 for 3 cycles with req_valid=4'b0011 -> req_ready=0, out_data/out_id stable; out_ready=1 -> drain plus new grant in the same cycle.
REQ-036 Counter edges: 300 saturating transfers -> sat_cnt=255; sat_cnt_clr with a saturating transfer in the same cycle -> sat_cnt=0.
REQ-037 Reset mid-operation: out_valid=1, rr_ptr=2, reset for 1 cycle -> out_valid=0, sat_cnt=0; next grant with req_valid=4'b1111 is requester 0.

Source files
------------

// File: rtl/psum_add_arbiter.sv
// rtl/psum_add_arbiter.sv - round-robin arbiter sharing one saturating psum adder
module psum_add_arbiter #(
    parameter int NREQ = 4,
    parameter int PSUM_DATA_SIZE = 12,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NREQ-1:0]                req_valid,
    input  logic [NREQ*PSUM_DATA_SIZE-1:0] req_a,
    input  logic [NREQ*PSUM_DATA_SIZE-1:0] req_b,
    output logic [NREQ-1:0]                req_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [PSUM_DATA_SIZE-1:0]      out_data,
    output logic [IDW-1:0]                 out_id,
    output logic [7:0]                     sat_cnt,
    input  logic                           sat_cnt_clr
);
    localparam int W = PSUM_DATA_SIZE;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic [IDW:0]   idx;
    logic           any_valid;
    logic           can_accept;
    logic           xfer;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W:0]     sum;
    logic [W-1:0]   sat_sum;
    logic           sat_hit;

    // Walk offsets from the far end down so the nearest valid requester to rr_ptr wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ))
                idx = idx - (IDW+1)'(NREQ);
            if (req_valid[idx[IDW-1:0]]) begin
                grant     = idx[IDW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign can_accept = ~out_valid | out_ready;
    assign xfer       = any_valid & can_accept & ~reset;

    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                req_ready[i] = xfer;
                a_sel        = req_a[i*W +: W];
                b_sel        = req_b[i*W +: W];
            end
        end
    end

    // Overflow shows up as the extra sign bit disagreeing with the result's MSB.
    always_comb begin
        sum     = {a_sel[W-1], a_sel} + {b_sel[W-1], b_sel};
        sat_hit = sum[W] ^ sum[W-1];
        sat_sum = sum[W-1:0];
        if (sat_hit)
            sat_sum = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sat_sum;
            out_id    <= grant;
            rr_ptr    <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || sat_cnt_clr)
            sat_cnt <= '0;
        else if (xfer && sat_hit && sat_cnt != 8'hFF)
            sat_cnt <= sat_cnt + 8'd1;
    end
endmodule
